// File: rtl/reg_byte_writer_pkg.sv
// Shared definitions for the register-to-memory byte store sequencer:
// state encoding, store-mode codes and the byte-lane selection rule.
package reg_byte_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR1  = 2'd1,
    ST_WR2  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MODE_WORD      = 2'b00,
    MODE_LOW       = 2'b01,
    MODE_HIGH      = 2'b10,
    MODE_WORD_SWAP = 2'b11
  } mode_t;

  function automatic logic is_single(input mode_t m);
    return (m == MODE_LOW) || (m == MODE_HIGH);
  endfunction

  // Word modes put the high byte first when first_high XOR swap; the second
  // byte is always the opposite lane.
  function automatic logic [7:0] pick_byte(input logic [15:0] w, input mode_t m,
                                           input logic first_high, input logic first);
    logic take_high;
    case (m)
      MODE_LOW:  take_high = 1'b0;
      MODE_HIGH: take_high = 1'b1;
      default:   take_high = (first_high ^ (m == MODE_WORD_SWAP)) ^ ~first;
    endcase
    return take_high ? w[15:8] : w[7:0];
  endfunction

endpackage

// File: rtl/reg_byte_writer.sv
// Stores a 16-bit register to an 8-bit memory bus as one or two byte writes,
// holding each write request stable until the memory acknowledges it.
module reg_byte_writer
  import reg_byte_writer_pkg::*;
#(
  parameter int FIRST_HIGH = 0
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  Mode,
  input  logic [15:0] Word,
  input  logic [15:0] Addr,
  output logic        Ready,
  output logic [15:0] MemAddr,
  output logic [7:0]  MemData,
  output logic        MemWr,
  input  logic        MemAck,
  output logic        Done
);

  localparam logic FH = (FIRST_HIGH != 0);

  state_t      state_q, state_d;
  logic [15:0] word_q, word_d;
  logic [15:0] addr_q, addr_d;
  mode_t       mode_q, mode_d;
  logic        ready_q, ready_d;
  logic        mem_wr_q, mem_wr_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_data_q, mem_data_d;
  logic        done_q, done_d;
  logic        accepted;

  assign accepted = mem_wr_q & MemAck;

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    addr_d     = addr_q;
    mode_d     = mode_q;
    ready_d    = ready_q;
    mem_wr_d   = mem_wr_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          // Bus outputs are registered, so the first byte is prepared from
          // the live inputs on the capture edge.
          word_d     = Word;
          addr_d     = Addr;
          mode_d     = mode_t'(Mode);
          ready_d    = 1'b0;
          mem_wr_d   = 1'b1;
          mem_addr_d = Addr;
          mem_data_d = pick_byte(Word, mode_t'(Mode), FH, 1'b1);
          state_d    = ST_WR1;
        end
      end
      ST_WR1: begin
        if (accepted) begin
          if (is_single(mode_q)) begin
            mem_wr_d = 1'b0;
            done_d   = 1'b1;
            state_d  = ST_FIN;
          end else begin
            mem_addr_d = addr_q + 16'd1;
            mem_data_d = pick_byte(word_q, mode_q, FH, 1'b0);
            state_d    = ST_WR2;
          end
        end
      end
      ST_WR2: begin
        if (accepted) begin
          mem_wr_d = 1'b0;
          done_d   = 1'b1;
          state_d  = ST_FIN;
        end
      end
      ST_FIN: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        ready_d  = 1'b1;
        mem_wr_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      word_q     <= '0;
      addr_q     <= '0;
      mode_q     <= MODE_WORD;
      ready_q    <= 1'b1;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      mode_q     <= mode_d;
      ready_q    <= ready_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      done_q     <= done_d;
    end
  end

  assign Ready   = ready_q;
  assign MemWr   = mem_wr_q;
  assign MemAddr = mem_addr_q;
  assign MemData = mem_data_q;
  assign Done    = done_q;

endmodule

// File: tb/tb_reg_byte_writer.sv
// Bench for reg_byte_writer: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a write-queue model.
module tb_reg_byte_writer;

  localparam int FHP = 0;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic [1:0]  Mode;
  logic [15:0] Word;
  logic [15:0] Addr;
  logic        Ready;
  logic [15:0] MemAddr;
  logic [7:0]  MemData;
  logic        MemWr;
  logic        MemAck;
  logic        Done;

  reg_byte_writer #(.FIRST_HIGH(FHP)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Mode(Mode), .Word(Word),
    .Addr(Addr), .Ready(Ready), .MemAddr(MemAddr), .MemData(MemData),
    .MemWr(MemWr), .MemAck(MemAck), .Done(Done)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [15:0] wlog_a[$];
  logic [7:0]  wlog_d[$];

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: pending byte writes as a queue of {addr,data}; ready/done flags.
  logic [23:0] mq[$];
  logic        m_valid = 1'b0;
  logic        m_ready = 1'b1;
  logic        m_done  = 1'b0;
  logic        m_rst   = 1'b0;
  logic [15:0] a1;
  logic [7:0]  lo, hi;
  logic        fhw;

  always @(negedge Clock) begin
    if (m_valid) begin
      chk("ready", {31'd0, Ready}, {31'd0, m_ready});
      chk("memwr", {31'd0, MemWr}, {31'd0, mq.size() != 0});
      chk("done", {31'd0, Done}, {31'd0, m_done});
      if (mq.size() != 0) begin
        chk("memaddr", {16'd0, MemAddr}, {16'd0, mq[0][23:8]});
        chk("memdata", {24'd0, MemData}, {24'd0, mq[0][7:0]});
      end
      if (m_rst) begin
        chk("rst_addr", {16'd0, MemAddr}, 32'd0);
        chk("rst_data", {24'd0, MemData}, 32'd0);
      end
    end
    if (MemWr && MemAck) begin
      wlog_a.push_back(MemAddr);
      wlog_d.push_back(MemData);
    end
    if (Reset) begin
      mq.delete();
      m_valid = 1'b1;
      m_ready = 1'b1;
      m_done  = 1'b0;
      m_rst   = 1'b1;
    end else if (m_valid) begin
      if (m_done) begin
        m_done  = 1'b0;
        m_ready = 1'b1;
      end else if (m_ready) begin
        if (Start) begin
          lo = Word[7:0];
          hi = Word[15:8];
          a1 = Addr + 16'd1;
          case (Mode)
            2'b01: mq.push_back({Addr, lo});
            2'b10: mq.push_back({Addr, hi});
            default: begin
              fhw = (FHP != 0) ^ (Mode == 2'b11);
              mq.push_back({Addr, fhw ? hi : lo});
              mq.push_back({a1, fhw ? lo : hi});
            end
          endcase
          m_ready = 1'b0;
          m_rst   = 1'b0;
        end
      end else if (mq.size() != 0 && MemAck) begin
        void'(mq.pop_front());
        if (mq.size() == 0) m_done = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_store(input logic [15:0] w, input logic [15:0] a, input logic [1:0] m,
                          input int w1, input int w2, input bit ign,
                          input logic [15:0] ea0, input logic [7:0] ed0,
                          input logic [15:0] ea1, input logic [7:0] ed1);
    int k;
    int n;
    int base;
    bit wordm;
    k = 0;
    while (!Ready && k < 20) begin
      step();
      k++;
    end
    chk("ready_wait", {31'd0, Ready}, 32'd1);
    base  = wlog_a.size();
    wordm = (m == 2'b00) || (m == 2'b11);
    Word = w; Addr = a; Mode = m; Start = 1'b1; MemAck = 1'b1;
    step();
    n = cyc;
    Start = 1'b0; Word = 16'($urandom); Addr = 16'($urandom); Mode = 2'($urandom);
    repeat (w1) begin MemAck = 1'b0; step(); end
    MemAck = 1'b1;
    step();
    if (wordm) begin
      repeat (w2) begin
        MemAck = 1'b0;
        if (ign) begin Start = 1'b1; Word = 16'h7777; Addr = 16'h1111; Mode = 2'b01; end
        step();
      end
      MemAck = 1'b1;
      if (ign) Start = 1'b1;
      step();
      Start = 1'b0;
    end
    chk("done_pulse", {31'd0, Done}, 32'd1);
    chk("done_latency", cyc - n, wordm ? 2 + w1 + w2 : 1 + w1);
    step();
    chk("ready_back", {31'd0, Ready}, 32'd1);
    chk("done_once", {31'd0, Done}, 32'd0);
    chk("nwrites", wlog_a.size() - base, wordm ? 2 : 1);
    if (wlog_a.size() > base) begin
      chk("w0_addr", {16'd0, wlog_a[base]}, {16'd0, ea0});
      chk("w0_data", {24'd0, wlog_d[base]}, {24'd0, ed0});
    end
    if (wordm && wlog_a.size() > base + 1) begin
      chk("w1_addr", {16'd0, wlog_a[base+1]}, {16'd0, ea1});
      chk("w1_data", {24'd0, wlog_d[base+1]}, {24'd0, ed1});
    end
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Mode = 2'b00; Word = '0; Addr = '0; MemAck = 1'b0;
    step(); step();
    Reset = 1'b0;
    chk("rst_ready", {31'd0, Ready}, 32'd1);
    chk("rst_memwr", {31'd0, MemWr}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_memaddr", {16'd0, MemAddr}, 32'd0);
    chk("rst_memdata", {24'd0, MemData}, 32'd0);
    step();

    do_store(16'hA55A, 16'h0040, 2'b00, 0, 0, 1'b0, 16'h0040, 8'h5A, 16'h0041, 8'hA5);
    do_store(16'h1234, 16'h0010, 2'b01, 0, 0, 1'b0, 16'h0010, 8'h34, 16'h0000, 8'h00);
    do_store(16'h1234, 16'h0010, 2'b10, 0, 0, 1'b0, 16'h0010, 8'h12, 16'h0000, 8'h00);
    do_store(16'hA55A, 16'h0040, 2'b00, 3, 2, 1'b0, 16'h0040, 8'h5A, 16'h0041, 8'hA5);
    do_store(16'hBEEF, 16'hFFFF, 2'b11, 0, 0, 1'b0, 16'hFFFF, 8'hBE, 16'h0000, 8'hEF);
    do_store(16'hC3D4, 16'h2000, 2'b00, 1, 2, 1'b1, 16'h2000, 8'hD4, 16'h2001, 8'hC3);

    // Reset asserted while WR2 is waiting on the memory
    Word = 16'hA55A; Addr = 16'h0040; Mode = 2'b00; Start = 1'b1; MemAck = 1'b1;
    step();
    Start = 1'b0; MemAck = 1'b1;
    step();
    MemAck = 1'b0;
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("midrst_memwr", {31'd0, MemWr}, 32'd0);
    chk("midrst_ready", {31'd0, Ready}, 32'd1);
    chk("midrst_done", {31'd0, Done}, 32'd0);
    step();
    chk("midrst_nodone", {31'd0, Done}, 32'd0);
    do_store(16'hA55A, 16'h0040, 2'b00, 0, 0, 1'b0, 16'h0040, 8'h5A, 16'h0041, 8'hA5);

    repeat (3000) begin
      Reset  = ($urandom_range(0, 99) == 0);
      Start  = ($urandom_range(0, 2) == 0);
      Word   = 16'($urandom);
      Addr   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      Mode   = 2'($urandom);
      MemAck = ($urandom_range(0, 3) != 0);
      step();
    end
    Reset = 1'b0; Start = 1'b0; MemAck = 1'b1;
    repeat (8) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/reg_byte_writer.md
# reg_byte_writer

Writes the contents of a 16-bit datapath register to the 8-bit memory bus, one byte per memory write. It is the store-side counterpart to the register byte-load modes (load low byte, load high byte), which assemble a 16-bit value from memory. The block sits between the register file / ALU output and the 8-bit data memory. The control unit uses it for word and byte stores (register to memory).

## Interface
Parameters:
- `FIRST_HIGH`, default 0. Selects which byte of a word store goes first.
  - 0: low byte goes to `Addr`, high byte to `Addr+1` (little-endian).
  - 1: high byte goes to `Addr`, low byte to `Addr+1`.

Ports:
- `Clock`, input, 1. Single clock; all state changes on its rising edge.
- `Reset`, input, 1. Synchronous, active-high.
- `Start`, input, 1. Request a store. Sampled only while `Ready` = 1.
- `Mode`, input, 2. Store type:
  - 00: word (two bytes)
  - 01: low byte only
  - 10: high byte only
  - 11: word in the order opposite to `FIRST_HIGH`
- `Word`, input, 16. Register value to store. Captured on `Start` acceptance.
- `Addr`, input, 16. Base byte address. Captured on `Start` acceptance.
- `Ready`, output, 1. 1 only in IDLE.
- `MemAddr`, output, 16. Address of the current byte write.
- `MemData`, output, 8. Data of the current byte write.
- `MemWr`, output, 1. Write request. Held until acknowledged.
- `MemAck`, input, 1. Memory accepts the write on a rising edge where `MemWr` = 1 and `MemAck` = 1.
- `Done`, output, 1. One-cycle pulse after the last byte is accepted.

## Operation
- All outputs are registered. On `Reset`:
  - state = IDLE
  - `Ready` = 1
  - `MemWr` = 0, `Done` = 0
  - `MemAddr` = 16'h0000, `MemData` = 8'h00
  - captured word, address and mode cleared.
- State machine:
  - **IDLE**:
    - `Start` = 1: capture `Word`, `Addr`, `Mode`, then go to WR1.
    - Otherwise stay.
  - **WR1**:
    - Drive `MemWr` = 1, `MemAddr` = captured address, `MemData` = first byte.
    - On acceptance: single-byte mode goes to FIN; word mode goes to WR2.
    - Without acceptance: stay, with all bus outputs held stable.
  - **WR2**:
    - Drive `MemWr` = 1, `MemAddr` = captured address + 1, `MemData` = second byte.
    - On acceptance, go to FIN. Otherwise hold.
  - **FIN**: `Done` = 1, `MemWr` = 0, then go to IDLE.
- Byte selection:
  - Mode 01 writes `Word[7:0]`. Mode 10 writes `Word[15:8]`. Both write to `Addr`.
  - Word modes: the first byte is high when (`FIRST_HIGH` XOR (`Mode` == 11)), otherwise low. The second byte is the other one.
- Address arithmetic is 16-bit modulo: base 16'hFFFF gives second address 16'h0000.
- `Start` while not IDLE is ignored. It is not queued. `Word`/`Addr`/`Mode` changes after capture have no effect.
- `MemAck` while `MemWr` = 0 is ignored.
- `Reset` mid-operation:
  - Return to IDLE on that edge; no further bytes are written.
  - A byte acknowledged on the same edge as `Reset` counts as written, but `Done` is not pulsed.

## Timing
- `Start` sampled at edge n: `MemWr` is high from cycle n+1.
- Zero-wait memory (`MemAck` tied high):
  - Word store: WR1 in cycle n+1, WR2 in cycle n+2, `Done` in cycle n+3, `Ready` in cycle n+4.
  - Byte store: WR1 in cycle n+1, `Done` in cycle n+2, `Ready` in cycle n+3.
- Each memory wait cycle adds exactly one cycle.
- Back-to-back: the earliest next `Start` acceptance is the edge that ends the first IDLE cycle after FIN.
- `MemWr`, `MemAddr` and `MemData` never change while a write is pending and unacknowledged.

## Structure
- A shared package holds:
  - the state encoding constants (IDLE, WR1, WR2, FIN)
  - the `Mode` codes (MODE_WORD, MODE_LOW, MODE_HIGH, MODE_WORD_SWAP)
- Single module, no sub-modules. The second-address incrementer is an inline 16-bit add.

## Test plan
- **Word store, zero wait:** `Reset`, then `Start` with `Word`=16'hA55A, `Addr`=16'h0040, `Mode`=00, `FIRST_HIGH`=0, `MemAck`=1.
  - Required: writes (0040, 5A) then (0041, A5) on consecutive cycles.
  - `Done` pulses once; `Ready` returns 4 cycles after `Start`.
- **Byte modes:**
  - `Mode`=01 with `Word`=16'h1234, `Addr`=16'h0010 gives a single write (0010, 34).
  - `Mode`=10 gives (0010, 12).
  - In both cases `Done` follows one cycle later.
- **Wait states:** word store with `MemAck` low for 3 cycles during WR1 and 2 cycles during WR2.
  - Bus outputs stay stable while waiting.
  - Exactly two writes occur; `Done` arrives 5 cycles later than in the zero-wait case.
- **Wrap and order:** `Addr`=16'hFFFF, `Word`=16'hBEEF, `Mode`=11, `FIRST_HIGH`=0.
  - Required: writes (FFFF, BE) then (0000, EF).
- **Ignored Start:** pulse `Start` with new data during WR2.
  - The original transfer completes unchanged; no extra writes occur; `Ready`=1 afterwards.
- **Reset mid-op:** assert `Reset` during WR2 with `MemAck`=0.
  - Next cycle: `MemWr`=0, `Ready`=1, no `Done`.
  - A following word store behaves exactly as in the first scenario.
